// File: rtl/pixelize_stream_hold.sv
// Avalon-ST horizontal pixelizer: within each row, every pixel of a 2^k block is
// replaced by the block's first pixel. One registered output stage, ready latency 0.
module pixelize_stream_hold #(
  parameter int unsigned DATA_W    = 24,
  parameter int unsigned IMG_WIDTH = 640,
  parameter int unsigned COL_W     = 10,
  parameter int unsigned MAX_LOG2  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        ctrl,
  input  logic [DATA_W-1:0] snk_data,
  input  logic              snk_valid,
  input  logic              snk_sop,
  input  logic              snk_eop,
  output logic              snk_ready,
  output logic [DATA_W-1:0] src_data,
  output logic              src_valid,
  output logic              src_sop,
  output logic              src_eop,
  input  logic              src_ready,
  output logic              busy
);

  logic [COL_W-1:0]  col_q, col_d;
  logic [DATA_W-1:0] hold_q;
  logic              cfg_en_q;
  logic [2:0]        cfg_log2_q;

  logic              accept;
  logic [2:0]        ctrl_log2;
  logic              eff_en;
  logic [2:0]        eff_log2;
  logic [COL_W-1:0]  eff_col;
  logic [COL_W-1:0]  blk_mask;
  logic              first_in_block;
  logic              take_new;
  logic [DATA_W-1:0] data_out;

  assign snk_ready = ~src_valid | src_ready;
  assign accept    = snk_valid & snk_ready;

  assign ctrl_log2 = (ctrl[2:0] > 3'(MAX_LOG2)) ? 3'(MAX_LOG2) : ctrl[2:0];

  // An SOP beat already runs with the config and column it is about to latch.
  assign eff_en   = snk_sop ? ctrl[3]   : cfg_en_q;
  assign eff_log2 = snk_sop ? ctrl_log2 : cfg_log2_q;
  assign eff_col  = snk_sop ? '0        : col_q;

  assign blk_mask       = (COL_W'(1) << eff_log2) - COL_W'(1);
  assign first_in_block = (eff_col & blk_mask) == '0;
  assign take_new       = ~eff_en | first_in_block;
  assign data_out       = take_new ? snk_data : hold_q;

  always_comb begin
    col_d = eff_col + COL_W'(1);
    if (snk_eop || eff_col == COL_W'(IMG_WIDTH - 1)) begin
      col_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_q      <= '0;
      hold_q     <= '0;
      cfg_en_q   <= 1'b0;
      cfg_log2_q <= '0;
      busy       <= 1'b0;
    end else if (accept) begin
      col_q <= col_d;
      if (take_new) begin
        hold_q <= snk_data;
      end
      if (snk_sop) begin
        cfg_en_q   <= ctrl[3];
        cfg_log2_q <= ctrl_log2;
      end
      // EOP wins so a single-pixel frame leaves busy low.
      if (snk_eop) begin
        busy <= 1'b0;
      end else if (snk_sop) begin
        busy <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src_valid <= 1'b0;
      src_data  <= '0;
      src_sop   <= 1'b0;
      src_eop   <= 1'b0;
    end else if (accept) begin
      src_valid <= 1'b1;
      src_data  <= data_out;
      src_sop   <= snk_sop;
      src_eop   <= snk_eop;
    end else if (src_ready) begin
      src_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pixelize_stream_hold.sv
// Randomized scoreboard bench for pixelize_stream_hold; the reference model picks
// each output from a buffered copy of the current row by block arithmetic.
module tb_pixelize_stream_hold;

  localparam int unsigned DATA_W    = 24;
  localparam int unsigned IMG_WIDTH = 640;
  localparam int unsigned COL_W     = 10;
  localparam int unsigned MAX_LOG2  = 5;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              sop;
    logic              eop;
  } beat_t;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [3:0]        ctrl = 4'b0000;
  logic [DATA_W-1:0] snk_data = '0;
  logic              snk_valid = 1'b0;
  logic              snk_sop = 1'b0;
  logic              snk_eop = 1'b0;
  logic              snk_ready;
  logic [DATA_W-1:0] src_data;
  logic              src_valid;
  logic              src_sop;
  logic              src_eop;
  logic              src_ready = 1'b1;
  logic              busy;

  pixelize_stream_hold #(
    .DATA_W   (DATA_W),
    .IMG_WIDTH(IMG_WIDTH),
    .COL_W    (COL_W),
    .MAX_LOG2 (MAX_LOG2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .ctrl     (ctrl),
    .snk_data (snk_data),
    .snk_valid(snk_valid),
    .snk_sop  (snk_sop),
    .snk_eop  (snk_eop),
    .snk_ready(snk_ready),
    .src_data (src_data),
    .src_valid(src_valid),
    .src_sop  (src_sop),
    .src_eop  (src_eop),
    .src_ready(src_ready),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    errors = 0;
  beat_t exp_q[$];

  // Reference model state: frame config, position in the row, and the row seen so far.
  bit                m_en = 0;
  int                m_bs = 1;
  int                m_col = 0;
  bit                m_busy = 0;
  logic [DATA_W-1:0] rowbuf[IMG_WIDTH];

  int  rdy_mode = 0;   // 0: src_ready always high, 1: random
  bit  expect_no_stall = 0;

  always @(posedge clk) begin
    #1;
    src_ready = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
  end

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every presented beat must match the queue head; popped when it leaves.
  always @(negedge clk) begin
    if (!reset && src_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", 1, 0);
      end else begin
        check("src_data", src_data, exp_q[0].data);
        check("src_sop", src_sop, exp_q[0].sop);
        check("src_eop", src_eop, exp_q[0].eop);
        if (src_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic model_beat(input logic [DATA_W-1:0] d, input bit sop, input bit eop,
                            input logic [3:0] c);
    beat_t b;
    logic [DATA_W-1:0] e;
    if (sop) begin
      m_en  = c[3];
      m_bs  = 1 << ((int'(c[2:0]) > MAX_LOG2) ? MAX_LOG2 : int'(c[2:0]));
      m_col = 0;
    end
    rowbuf[m_col] = d;
    e = m_en ? rowbuf[m_col - (m_col % m_bs)] : d;
    b.data = e;
    b.sop  = sop;
    b.eop  = eop;
    exp_q.push_back(b);
    if (eop) m_busy = 0;
    else if (sop) m_busy = 1;
    m_col = (eop || m_col == IMG_WIDTH - 1) ? 0 : m_col + 1;
  endtask

  // Called at posedge+1; returns at posedge+1 after the beat is accepted.
  task automatic send(input logic [DATA_W-1:0] d, input bit sop, input bit eop);
    bit acc;
    logic [3:0] c;
    int tries;
    snk_data  = d;
    snk_sop   = sop;
    snk_eop   = eop;
    snk_valid = 1'b1;
    acc   = 0;
    tries = 0;
    while (!acc && tries < 200) begin
      @(negedge clk);
      acc = snk_ready;
      c   = ctrl;
      @(posedge clk);
      #1;
      tries++;
    end
    if (!acc) begin
      check("accept_timeout", 0, 1);
    end else begin
      if (expect_no_stall) check("snk_ready_first_try", tries, 1);
      model_beat(d, sop, eop, c);
      check("latency_valid", src_valid, 1);
      check("busy", busy, m_busy);
    end
  endtask

  task automatic stop();
    snk_valid = 1'b0;
    snk_sop   = 1'b0;
    snk_eop   = 1'b0;
  endtask

  task automatic send_frame(input int n, input bit ramp, input int row_off);
    for (int i = 0; i < n; i++) begin
      send(ramp ? DATA_W'(row_off * 2048 + (i % IMG_WIDTH) + (i / IMG_WIDTH) * 2048)
                : DATA_W'($urandom), i == 0, i == n - 1);
    end
    stop();
  endtask

  task automatic pulse_reset();
    stop();
    reset = 1'b1;
    exp_q.delete();
    m_en = 0; m_bs = 1; m_col = 0; m_busy = 0;
    @(negedge clk);
    check("rst_src_valid", src_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_src_data", src_data, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(posedge clk);
      n++;
    end
    check("drain_empty", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_src_valid", src_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_src_data", src_data, 0);
    check("reset_src_sop", src_sop, 0);
    check("reset_src_eop", src_eop, 0);
    check("reset_snk_ready", snk_ready, 1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Passthrough ramp row, full throughput
    expect_no_stall = 1;
    ctrl = 4'b0110;
    send_frame(IMG_WIDTH, 1, 0);
    drain();
    check("busy_after_frame", busy, 0);

    // Block 4 ramp row
    ctrl = 4'b1010;
    send_frame(IMG_WIDTH, 1, 0);
    drain();

    // Block code 7 clamps to 32, two rows in one frame
    ctrl = 4'b1111;
    send_frame(2 * IMG_WIDTH, 1, 1);
    drain();
    expect_no_stall = 0;

    // Mid-frame ctrl change is ignored until the next SOP
    ctrl = 4'b1001;
    for (int i = 0; i < 400; i++) begin
      if (i == 150) ctrl = 4'b0000;
      send(DATA_W'($urandom), i == 0, i == 399);
    end
    stop();
    send_frame(100, 0, 0);
    drain();

    // Block 2 with random backpressure and random input gaps
    rdy_mode = 1;
    ctrl = 4'b1001;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        stop();
        @(posedge clk);
        #1;
      end
      send(DATA_W'($urandom), i == 0, i == 299);
    end
    stop();
    drain();

    // Random ctrl codes and frame lengths under backpressure
    for (int f = 0; f < 6; f++) begin
      ctrl = 4'($urandom);
      send_frame(int'($urandom_range(1, 700)), 0, 0);
    end
    drain();
    rdy_mode = 0;

    // Mid-frame SOP, then a single-pixel frame
    ctrl = 4'b1010;
    for (int i = 0; i < 20; i++) send(DATA_W'($urandom), i == 0, 1'b0);
    ctrl = 4'b1011;
    for (int i = 0; i < 30; i++) send(DATA_W'($urandom), i == 0, i == 29);
    send(DATA_W'($urandom), 1'b1, 1'b1);
    stop();
    drain();
    check("busy_single_pixel", busy, 0);

    // Reset at pixel 100, passthrough until next SOP, then pixelize from column 0
    ctrl = 4'b1010;
    for (int i = 0; i < 100; i++) send(DATA_W'(i), i == 0, 1'b0);
    pulse_reset();
    for (int i = 0; i < 10; i++) send(DATA_W'($urandom), 1'b0, 1'b0);
    ctrl = 4'b1011;
    send_frame(300, 0, 0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
